// File: rtl/alu_wb_master.sv
// Single-outstanding Wishbone classic master.
// A command is accepted in IDLE, replayed on the bus in BUS until the slave
// acknowledges it or the cycle watchdog expires, and its result is presented
// in RESP until the consumer takes it. Every output comes straight from a flop.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The side asserting valid holds its payload stable until that
// edge. Ready may depend on nothing but registered state.
module alu_wb_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   input  logic [3:0]  cmd_sel_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Watchdog fires when the counter reaches TIMEOUT-1, giving exactly
   // TIMEOUT strobe cycles. TIMEOUT of zero turns the watchdog off.
   localparam logic       LP_TO_EN   = (TIMEOUT != 0);
   localparam logic [7:0] LP_TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic        w_cmd_ready_nxt;
   logic        w_rsp_valid_nxt;
   logic [31:0] w_rsp_dat_nxt;
   logic        w_rsp_err_nxt;
   logic        w_cyc_nxt;
   logic        w_stb_nxt;
   logic        w_we_nxt;
   logic [3:0]  w_sel_nxt;
   logic [31:0] w_adr_nxt;
   logic [31:0] w_dat_nxt;

   // Next-state and next-output logic; every register holds unless changed.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_cmd_ready_nxt = cmd_ready_o;
      w_rsp_valid_nxt = rsp_valid_o;
      w_rsp_dat_nxt   = rsp_dat_o;
      w_rsp_err_nxt   = rsp_err_o;
      w_cyc_nxt       = wbm_cyc_o;
      w_stb_nxt       = wbm_stb_o;
      w_we_nxt        = wbm_we_o;
      w_sel_nxt       = wbm_sel_o;
      w_adr_nxt       = wbm_adr_o;
      w_dat_nxt       = wbm_dat_o;

      case (r_state)
         S_IDLE: begin
            w_cmd_ready_nxt = 1'b1;
            if (cmd_valid_i && cmd_ready_o) begin
               // The command fields are captured here and nowhere else.
               w_cmd_ready_nxt = 1'b0;
               w_cnt_nxt       = 8'd0;
               w_cyc_nxt       = 1'b1;
               w_stb_nxt       = 1'b1;
               w_we_nxt        = cmd_we_i;
               w_sel_nxt       = cmd_sel_i;
               w_adr_nxt       = cmd_adr_i;
               w_dat_nxt       = cmd_we_i ? cmd_dat_i : 32'd0;
               w_state_nxt     = S_BUS;
            end
         end

         S_BUS: begin
            // Ack is tested first so that it wins over a same-cycle timeout.
            if (wbm_ack_i || (LP_TO_EN && (r_cnt == LP_TO_LAST))) begin
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = !wbm_ack_i;
               w_rsp_dat_nxt   = (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : 32'd0;
               w_cyc_nxt       = 1'b0;
               w_stb_nxt       = 1'b0;
               w_we_nxt        = 1'b0;
               w_sel_nxt       = 4'd0;
               w_adr_nxt       = 32'd0;
               w_dat_nxt       = 32'd0;
               w_state_nxt     = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         S_RESP: begin
            if (rsp_ready_i) begin
               w_rsp_valid_nxt = 1'b0;
               w_rsp_dat_nxt   = 32'd0;
               w_rsp_err_nxt   = 1'b0;
               w_cmd_ready_nxt = 1'b1;
               w_state_nxt     = S_IDLE;
            end
         end

         default: begin
            w_state_nxt     = S_IDLE;
            w_cmd_ready_nxt = 1'b0;
            w_rsp_valid_nxt = 1'b0;
            w_cyc_nxt       = 1'b0;
            w_stb_nxt       = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears the bus without waiting for a clock.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= 32'd0;
         rsp_err_o   <= 1'b0;
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= 4'd0;
         wbm_adr_o   <= 32'd0;
         wbm_dat_o   <= 32'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         cmd_ready_o <= w_cmd_ready_nxt;
         rsp_valid_o <= w_rsp_valid_nxt;
         rsp_dat_o   <= w_rsp_dat_nxt;
         rsp_err_o   <= w_rsp_err_nxt;
         wbm_cyc_o   <= w_cyc_nxt;
         wbm_stb_o   <= w_stb_nxt;
         wbm_we_o    <= w_we_nxt;
         wbm_sel_o   <= w_sel_nxt;
         wbm_adr_o   <= w_adr_nxt;
         wbm_dat_o   <= w_dat_nxt;
      end
   end

endmodule

// File: tb/tb_alu_wb_master.sv
// Directed bench for alu_wb_master: instance A (TIMEOUT=4) carries most
// scenarios, instance B (TIMEOUT=2) covers ack coinciding with the watchdog.
// Expected responses {err, dat} are queued when a command is issued and
// popped when a response is observed.
module tb_alu_wb_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_we, rsp_ready, ack;
   logic [31:0] cmd_adr, cmd_dat, dat_i;
   logic [3:0]  cmd_sel;
   logic        cmd_ready, rsp_valid, rsp_err, cyc, stb, we;
   logic [31:0] rsp_dat, adr, dat_o;
   logic [3:0]  sel;

   logic        b_cmd_valid, b_rsp_ready, b_ack;
   logic [31:0] b_dat_i;
   logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_cyc, b_stb, b_we;
   logic [31:0] b_rsp_dat, b_adr, b_dat_o;
   logic [3:0]  b_sel;

   logic [32:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   alu_wb_master #(.TIMEOUT(4)) u_dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
      .rsp_err_o(rsp_err), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
      .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
      .wbm_dat_i(dat_i), .wbm_ack_i(ack)
   );

   alu_wb_master #(.TIMEOUT(2)) u_dut_b (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_dat_o(b_rsp_dat),
      .rsp_err_o(b_rsp_err), .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we),
      .wbm_sel_o(b_sel), .wbm_adr_o(b_adr), .wbm_dat_o(b_dat_o),
      .wbm_dat_i(b_dat_i), .wbm_ack_i(b_ack)
   );

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic obs_err, input logic [31:0] obs_dat);
      logic [32:0] e;
      check({tag, "_qnonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_err"}, 64'(obs_err), 64'(e[32]));
         check({tag, "_dat"}, 64'(obs_dat), 64'(e[31:0]));
      end
   endtask

   // Offer one command to instance A and scramble the fields after acceptance.
   task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
      for (int i = 0; i < 20 && !cmd_ready; i++) tick();
      check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
      cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      cmd_we = ~w; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = ~s;
   endtask

   task automatic check_bus(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      check({tag, "_cyc_stb"}, 64'({cyc, stb}), 64'd3);
      check({tag, "_we"},  64'(we), 64'(w));
      check({tag, "_adr"}, 64'(adr), 64'(a));
      check({tag, "_dat"}, 64'(dat_o), 64'(w ? d : 32'd0));
      check({tag, "_sel"}, 64'(sel), 64'(s));
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
   endtask

   task automatic accept_rsp(input string tag);
      for (int i = 0; i < 20 && !rsp_valid; i++) tick();
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
      pop_check(tag, rsp_err, rsp_dat);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_rsp_valid_clr"}, 64'(rsp_valid), 64'd0);
      check({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
   endtask

   // Write acknowledged on the first strobe cycle.
   task automatic write_ack1(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
      exp_q.push_back({1'b0, 32'd0});
      do_cmd(1'b1, a, d, s);
      check_bus(tag, 1'b1, a, d, s);
      ack = 1'b1; dat_i = $urandom;
      tick();
      ack = 1'b0;
      check({tag, "_cyc_drop"}, 64'({cyc, stb, we}), 64'd0);
      accept_rsp(tag);
   endtask

   initial begin
      logic [31:0] rd;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
      cmd_sel = '0; rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;
      b_cmd_valid = 1'b0; b_rsp_ready = 1'b0; b_ack = 1'b0; b_dat_i = '0;

      // Reset state.
      tick(); tick();
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_outs", 64'({rsp_valid, rsp_err, cyc, stb, we}), 64'd0);
      check("rst_buses", 64'(rsp_dat | adr | dat_o | 32'(sel)), 64'd0);
      rst_n = 1'b1;
      tick();
      check("rel_cmd_ready", 64'(cmd_ready), 64'd1);

      // Single-cycle write.
      write_ack1("wr", 32'h3000_0004, 32'h0000_00A5, 4'hF);

      // Read with three wait states; fields scrambled after accept must not leak.
      exp_q.push_back({1'b0, 32'h1234_5678});
      do_cmd(1'b0, 32'h3000_0008, 32'hDEAD_BEEF, 4'hF);
      for (int i = 0; i < 3; i++) begin
         check_bus($sformatf("rd_wait%0d", i), 1'b0, 32'h3000_0008, 32'd0, 4'hF);
         dat_i = $urandom;
         tick();
      end
      ack = 1'b1; dat_i = 32'h1234_5678;
      check_bus("rd_ack", 1'b0, 32'h3000_0008, 32'd0, 4'hF);
      tick();
      ack = 1'b0; dat_i = $urandom;
      check("rd_cyc_drop", 64'({cyc, stb}), 64'd0);
      accept_rsp("rd");

      // Timeout after exactly four strobe cycles, then a normal write.
      exp_q.push_back({1'b1, 32'd0});
      do_cmd(1'b0, 32'h3000_0010, 32'h0, 4'h3);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("to_stb%0d", i), 64'({cyc, stb, rsp_valid}), 64'd6);
         dat_i = $urandom;
         tick();
      end
      check("to_cyc_drop", 64'({cyc, stb}), 64'd0);
      accept_rsp("to");
      write_ack1("post_to_wr", 32'h3000_0020, 32'h5A5A_0001, 4'h6);

      // Response backpressure for five cycles.
      rd = $urandom;
      exp_q.push_back({1'b0, rd});
      do_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hC);
      ack = 1'b1; dat_i = rd;
      tick();
      ack = 1'b0; dat_i = ~rd;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_hold%0d", i), {rsp_valid, rsp_err, cmd_ready, rsp_dat},
               {1'b1, 1'b0, 1'b0, rd});
         tick();
      end
      accept_rsp("bp");

      // Reset asserted mid-bus: bus drops before the next edge, no response later.
      do_cmd(1'b1, 32'h3000_0040, 32'h1111_2222, 4'hF);
      check("mid_stb_before", 64'(stb), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_bus", 64'({cyc, stb, cmd_ready, rsp_valid}), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_rel_cmd_ready", 64'(cmd_ready), 64'd1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("mid_no_rsp%0d", i), 64'({rsp_valid, cyc}), 64'd0);
         tick();
      end

      // Spurious ack while idle changes nothing.
      ack = 1'b1; dat_i = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("spur%0d", i), 64'({cmd_ready, rsp_valid, cyc, stb}), 64'd8);
      end
      ack = 1'b0;
      write_ack1("post_spur_wr", 32'h3000_0050, 32'hABCD_0000, 4'h1);

      // Instance B: ack lands on the cycle the watchdog would fire; ack wins.
      exp_q.push_back({1'b0, 32'hCAFE_F00D});
      check("b_ready", 64'(b_cmd_ready), 64'd1);
      cmd_we = 1'b0; cmd_adr = 32'h3000_0060; cmd_sel = 4'hF; b_cmd_valid = 1'b1;
      tick();
      b_cmd_valid = 1'b0; cmd_adr = $urandom;
      check("b_stb0", 64'({b_cyc, b_stb, b_adr}), {32'd0, 2'b11, 32'h3000_0060});
      tick();
      check("b_stb1", 64'({b_cyc, b_stb}), 64'd3);
      b_ack = 1'b1; b_dat_i = 32'hCAFE_F00D;
      tick();
      b_ack = 1'b0; b_dat_i = '0;
      check("b_rsp_valid", 64'({b_rsp_valid, b_cyc}), 64'd2);
      pop_check("b_coinc", b_rsp_err, b_rsp_dat);
      b_rsp_ready = 1'b1;
      tick();
      b_rsp_ready = 1'b0;
      check("b_idle", 64'({b_rsp_valid, b_cmd_ready}), 64'd1);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
